// File: rtl/ped_timer_pkg.sv
// rtl/ped_timer_pkg.sv - command codes, state encoding and helpers for ped_timer
package ped_timer_pkg;

    localparam logic [3:0] SEL_NULL = 4'b0000;
    localparam logic [3:0] SEL_T1   = 4'b0001;
    localparam logic [3:0] SEL_T2   = 4'b0010;
    localparam logic [3:0] SEL_T3   = 4'b0011;
    localparam logic [3:0] SEL_T4   = 4'b0100;
    localparam logic [3:0] SEL_STOP = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Expiry pulse pattern for a latched timer index (0..3 -> T1..T4).
    function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler emitting one tick every PRESCALE cycles
//
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   clear - hold/restart the prescaler at 0 this edge
//   tick  - combinational; high in the last cycle of each PRESCALE period,
//           so the consuming edge is exactly PRESCALE edges after the clear
module tick_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign tick = !clear && (pre == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (clear || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

endmodule

// File: rtl/ped_timer.sv
// rtl/ped_timer.sv - four-preset unit timer with retrigger, stop and one-cycle expiry pulses
//
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   sel   - command code (NULL, T1..T4, STOP; others ignored)
//   ld    - load strobe qualifying the start codes (STOP acts without it)
//   T     - registered one-cycle expiry pulse, bit i-1 for timer i
//   busy  - registered, high while a timer is running
module ped_timer
    import ped_timer_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int T1_UNITS = 5,
    parameter int T2_UNITS = 10,
    parameter int T3_UNITS = 15,
    parameter int T4_UNITS = 20,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sel,
    input  logic       ld,
    output logic [3:0] T,
    output logic       busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       t_q, t_d;

    logic             is_start;
    logic             is_stop;
    logic [CNT_W-1:0] start_units;
    logic [1:0]       start_idx;
    logic             pre_clear;
    logic             tick;

    // Decode the command once; unused codes fall through as "no command".
    always_comb begin
        is_start    = 1'b0;
        start_units = '0;
        start_idx   = 2'd0;
        unique case (sel)
            SEL_T1: begin is_start = ld; start_units = CNT_W'(T1_UNITS); start_idx = 2'd0; end
            SEL_T2: begin is_start = ld; start_units = CNT_W'(T2_UNITS); start_idx = 2'd1; end
            SEL_T3: begin is_start = ld; start_units = CNT_W'(T3_UNITS); start_idx = 2'd2; end
            SEL_T4: begin is_start = ld; start_units = CNT_W'(T4_UNITS); start_idx = 2'd3; end
            default: ;
        endcase
    end

    assign is_stop = (sel == SEL_STOP);

    // Prescaler only runs while an uninterrupted timer is in progress; any
    // command (or idling) restarts it so a new period starts from the command edge.
    assign pre_clear = (state_q != ST_RUN) || is_start || is_stop;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (pre_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            t_q     <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            t_q     <= t_d;
        end
    end

    // Commands take priority over an expiry on the same edge, which is what
    // suppresses the old pulse on retrigger or stop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        t_d     = 4'b0000;
        if (is_stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (is_start) begin
            state_d = ST_RUN;
            cnt_d   = start_units;
            idx_d   = start_idx;
        end else if (state_q == ST_RUN && tick) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                t_d     = idx_onehot(idx_q);
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign T    = t_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_ped_timer.sv
// tb/tb_ped_timer.sv - self-checking bench for ped_timer with a deadline-based reference model
module tb_ped_timer;

    localparam int P  = 2;
    localparam int U1 = 3;
    localparam int U2 = 5;
    localparam int U3 = 2;
    localparam int U4 = 4;

    logic       clk;
    logic       reset;
    logic [3:0] sel;
    logic       ld;
    logic [3:0] T;
    logic       busy;

    int n_cmp;
    int n_bad;

    // Reference model: a running timer is just a deadline edge and an index.
    int   e_now;
    bit   m_run;
    int   m_dead;
    int   m_idx;
    logic [3:0] t_exp;

    ped_timer #(
        .PRESCALE (P),
        .T1_UNITS (U1),
        .T2_UNITS (U2),
        .T3_UNITS (U3),
        .T4_UNITS (U4),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .ld    (ld),
        .T     (T),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int units_of(input logic [3:0] s);
        case (s)
            4'd1: return U1;
            4'd2: return U2;
            4'd3: return U3;
            4'd4: return U4;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply a command for one edge, advance the model, and compare outputs.
    task automatic step(input logic [3:0] s, input logic l);
        bit is_stop;
        bit is_start;
        sel = s;
        ld  = l;
        @(posedge clk);
        is_stop  = (s == 4'hF);
        is_start = l && (units_of(s) > 0);
        t_exp = 4'b0000;
        if (is_stop) begin
            m_run = 1'b0;
        end else if (is_start) begin
            m_run  = 1'b1;
            m_dead = e_now + units_of(s) * P;
            m_idx  = int'(s) - 1;
        end else if (m_run && e_now == m_dead) begin
            t_exp = 4'b0001 << m_idx;
            m_run = 1'b0;
        end
        e_now++;
        #1;
        check("T", T, t_exp);
        check("busy", {3'b000, busy}, {3'b000, m_run});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("reset_T", T, 4'b0000);
        check("reset_busy", {3'b000, busy}, 4'b0000);
        reset = 1'b0;
        m_run = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        e_now = 0;
        m_run = 1'b0;
        m_dead = 0;
        m_idx = 0;
        reset = 1'b1;
        sel   = 4'h0;
        ld    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("por_T", T, 4'b0000);
        check("por_busy", {3'b000, busy}, 4'b0000);
        reset = 1'b0;
        idle(2);

        // Basic T1 expiry.
        step(4'h1, 1'b1);
        idle(5);
        check("basic_busy_before", {3'b000, busy}, 4'b0001);
        step(4'h0, 1'b0);
        check("basic_pulse", T, 4'b0001);
        check("basic_busy_after", {3'b000, busy}, 4'b0000);
        step(4'h0, 1'b0);
        check("basic_pulse_end", T, 4'b0000);

        // STOP without ld aborts.
        step(4'h1, 1'b1);
        idle(2);
        step(4'hF, 1'b0);
        check("stop_busy", {3'b000, busy}, 4'b0000);
        idle(17);

        // Retrigger T1 -> T2.
        step(4'h1, 1'b1);
        idle(3);
        step(4'h2, 1'b1);
        idle(9);
        step(4'h0, 1'b0);
        check("retrig_pulse", T, 4'b0010);
        idle(2);

        // Reset mid-run.
        step(4'h1, 1'b1);
        idle(3);
        do_reset();
        idle(17);

        // Ignored codes.
        step(4'h0, 1'b1);
        step(4'h5, 1'b1);
        step(4'h9, 1'b1);
        step(4'hE, 1'b1);
        check("ignored_busy", {3'b000, busy}, 4'b0000);
        idle(3);

        // Retrigger exactly on the expiry edge.
        step(4'h1, 1'b1);
        idle(5);
        step(4'h2, 1'b1);
        check("collide_no_t1", T, 4'b0000);
        idle(9);
        step(4'h0, 1'b0);
        check("collide_pulse", T, 4'b0010);
        idle(2);

        // STOP on the expiry edge.
        step(4'h4, 1'b1);
        idle(7);
        step(4'hF, 1'b1);
        check("stop_collide", T, 4'b0000);
        idle(3);

        // T3 and T4 end to end.
        step(4'h3, 1'b1);
        idle(5);
        step(4'h4, 1'b1);
        idle(10);

        // Randomized commands against the model.
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset();
            end else if (r < 10) begin
                step(4'(1 + $urandom_range(0, 3)), 1'b1);
            end else if (r < 13) begin
                step(4'hF, 1'($urandom_range(0, 1)));
            end else if (r < 20) begin
                step(4'($urandom_range(5, 14)), 1'($urandom_range(0, 1)));
            end else if (r < 25) begin
                step(4'(1 + $urandom_range(0, 3)), 1'b0);
            end else begin
                step(4'h0, 1'($urandom_range(0, 1)));
            end
        end
        idle(45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
